// File: rtl/branch_predictor_gshare_r1_if.sv
// Predictor port bundle: predict side and resolution side.
// master drives lookups and updates, slave is the predictor.
interface branch_predictor_gshare_r1_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int HIST_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] predictAddr;
  logic                  prediction;
  logic [HIST_WIDTH-1:0] predictHist;
  logic                  update;
  logic [ADDR_WIDTH-1:0] updateAddr;
  logic [HIST_WIDTH-1:0] updateHist;
  logic                  branchTaken;
  logic                  ready;

  modport master (
    output predictAddr, update, updateAddr,
    output updateHist, branchTaken,
    input  prediction, predictHist, ready
  );

  modport slave (
    input  predictAddr, update, updateAddr,
    input  updateHist, branchTaken,
    output prediction, predictHist, ready
  );
endinterface

// File: rtl/branch_predictor_gshare_r1.sv
// Gshare/bimodal branch predictor with init sweep.
// Define BPU_GSHARE_EN for gshare indexing, else bimodal.
module branch_predictor_gshare_r1 #(
  parameter int ADDR_WIDTH = 6,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  branch_predictor_gshare_r1_if.slave bp
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  ready_q;
  logic [HIST_WIDTH-1:0] ghr_q;
  logic [HIST_WIDTH-1:0] ghr_d;
  logic [CTR_WIDTH-1:0]  tbl_q [DEPTH];

  logic                  upd_en;
  logic [ADDR_WIDTH-1:0] pext;
  logic [ADDR_WIDTH-1:0] uext;
  logic [ADDR_WIDTH-1:0] pidx;
  logic [ADDR_WIDTH-1:0] uidx;
  logic [CTR_WIDTH-1:0]  ctr_rd;
  logic [CTR_WIDTH-1:0]  ctr_u;
  logic [CTR_WIDTH-1:0]  ctr_new;

  assign upd_en = bp.update & ready_q;

`ifdef BPU_GSHARE_EN
  // History shifts in each resolved direction; indices fold it in
  always_comb begin
    ghr_d = ghr_q;
    pext  = '0;
    uext  = '0;
    pext[HIST_WIDTH-1:0] = ghr_q;
    uext[HIST_WIDTH-1:0] = bp.updateHist;
    if (upd_en)
      ghr_d = (ghr_q << 1) | HIST_WIDTH'(bp.branchTaken);
  end
`else
  // Bimodal: history pinned to zero, plain PC indexing
  always_comb begin
    ghr_d = '0;
    pext  = '0;
    uext  = '0;
  end
`endif

  assign pidx = bp.predictAddr ^ pext;
  assign uidx = bp.updateAddr ^ uext;

  assign ctr_rd = tbl_q[pidx];
  assign ctr_u  = tbl_q[uidx];

  assign bp.prediction  = ready_q & ctr_rd[CTR_WIDTH-1];
  assign bp.predictHist = ghr_q;
  assign bp.ready       = ready_q;

  // Saturating step of the counter being resolved
  always_comb begin
    ctr_new = ctr_u;
    if (bp.branchTaken) begin
      if (ctr_u != CTR_MAX) ctr_new = ctr_u + 1'b1;
    end else begin
      if (ctr_u != '0) ctr_new = ctr_u - 1'b1;
    end
  end

  // Init sweep FSM; RUN only left through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Global history register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  // Counter table: no reset, rewritten by the sweep
  always_ff @(posedge clk) begin
    if (state_q == S_INIT)
      tbl_q[ptr_q] <= CTR_INIT;
    else if (upd_en)
      tbl_q[uidx] <= ctr_new;
  end
endmodule

// File: tb/tb_branch_predictor_gshare_r1.sv
// Testbench for branch_predictor_gshare_r1.
// Table/GHR reference model plus directed steps.
module tb_branch_predictor_gshare_r1;
  localparam int AW    = 6;
  localparam int CW    = 2;
  localparam int HW    = 4;
  localparam int DEPTH = 64;
  localparam int CMAX  = 3;
  localparam int CINIT = 1;
`ifdef BPU_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_gshare_r1_if #(
    .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) bp();
  branch_predictor_gshare_r1_if #(
    .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) bp3();

  branch_predictor_gshare_r1 #(
    .ADDR_WIDTH(AW), .CTR_WIDTH(CW), .HIST_WIDTH(HW)
  ) dut (.clk(clk), .rst(rst), .bp(bp));

  branch_predictor_gshare_r1 #(
    .ADDR_WIDTH(AW), .CTR_WIDTH(3), .HIST_WIDTH(HW)
  ) dut3 (.clk(clk), .rst(rst), .bp(bp3));

  int checks = 0;
  int failures = 0;
  int mdl [DEPTH];
  int mghr;
  int mcnt;

  function automatic int mpred(int a);
    int i;
    if (mcnt < DEPTH) return 0;
    i = (a ^ (GS ? mghr : 0)) & (DEPTH - 1);
    return (mdl[i] >= (1 << (CW - 1))) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (bp.update === 1'b1 && mcnt >= DEPTH) begin
      int i;
      i = (int'(bp.updateAddr) ^
           (GS ? int'(bp.updateHist) : 0)) & (DEPTH - 1);
      if (bp.branchTaken) begin
        if (mdl[i] < CMAX) mdl[i]++;
      end else if (mdl[i] > 0) begin
        mdl[i]--;
      end
      if (GS)
        mghr = ((mghr << 1) | int'(bp.branchTaken))
               & ((1 << HW) - 1);
    end
    @(posedge clk);
    #1;
    if (rst) mcnt++;
    chk("ready", bp.ready, int'(mcnt >= DEPTH));
  endtask

  task automatic probe(int pa);
    bp.predictAddr = AW'(pa);
    #1;
    chk("pred", bp.prediction, mpred(pa));
    chk("hist", bp.predictHist, GS ? mghr : 0);
  endtask

  task automatic idle();
    bp.update = 1'b0;  bp.updateAddr = '0;
    bp.updateHist = '0; bp.branchTaken = 1'b0;
    bp3.update = 1'b0; bp3.updateAddr = '0;
    bp3.updateHist = '0; bp3.branchTaken = 1'b0;
    bp3.predictAddr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #1;
    chk("rst_ready", bp.ready, 0);
    chk("rst_pred", bp.prediction, 0);
    chk("rst_hist", bp.predictHist, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mcnt = 0;
    mghr = 0;
    foreach (mdl[k]) mdl[k] = CINIT;
  endtask

  task automatic upd(int a, int h, bit t);
    bp.update = 1'b1;
    bp.updateAddr = AW'(a);
    bp.updateHist = HW'(h);
    bp.branchTaken = t;
    tick();
    bp.update = 1'b0;
  endtask

  task automatic upd3(int a, bit t);
    bp3.update = 1'b1;
    bp3.updateAddr = AW'(a);
    bp3.updateHist = '0;
    bp3.branchTaken = t;
    tick();
    bp3.update = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bp.predictAddr = '0;
    idle();
    do_reset();

    // Sweep with noisy updates that must be ignored
    repeat (DEPTH) begin
      bp.update = 1'($urandom);
      bp.updateAddr = AW'($urandom);
      bp.updateHist = HW'($urandom);
      bp.branchTaken = 1'($urandom);
      probe(int'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    idle();
    probe(int'($urandom_range(0, DEPTH - 1)));

`ifdef BPU_GSHARE_EN
    upd(0, 0, 1'b1);
    upd(0, 0, 1'b1);
    upd(0, 0, 1'b0);
    probe(9);
    chk("hist0110", bp.predictHist, 6);
`else
    upd(5, 0, 1'b1);
    upd(5, 0, 1'b1);
    probe(5);
    chk("bim_taken2", bp.prediction, 1);
    repeat (3) upd(5, 0, 1'b0);
    probe(5);
    chk("bim_nt3", bp.prediction, 0);
    upd(5, 0, 1'b0);
    probe(5);
    chk("bim_floor", bp.prediction, 0);
`endif

    // Same-index predict and update: no bypass
    bp.predictAddr = AW'(20 ^ mghr);
    bp.update = 1'b1;
    bp.updateAddr = AW'(20);
    bp.updateHist = '0;
    bp.branchTaken = 1'b1;
    #1;
    chk("same_cyc", bp.prediction, 0);
    tick();
    bp.update = 1'b0;
    bp.predictAddr = AW'(20 ^ mghr);
    #1;
    chk("same_next", bp.prediction, 1);

    // 3-bit counters: saturate at 7, fall back to 3
    repeat (10) upd3(3, 1'b1);
    bp3.predictAddr = AW'(GS ? (3 ^ 15) : 3);
    #1;
    chk("c3_sat", bp3.prediction, 1);
    repeat (3) upd3(3, 1'b0);
    bp3.predictAddr = AW'(GS ? (3 ^ 8) : 3);
    #1;
    chk("c3_four", bp3.prediction, 1);
    upd3(3, 1'b0);
    bp3.predictAddr = AW'(3);
    #1;
    chk("c3_three", bp3.prediction, 0);

    // Random traffic against the model
    repeat (400) begin
      bp.update = 1'($urandom);
      bp.updateAddr = AW'($urandom);
      bp.updateHist = $urandom_range(0, 1) ?
        HW'(mghr) : HW'($urandom);
      bp.branchTaken = 1'($urandom);
      probe(int'($urandom_range(0, DEPTH - 1)));
      tick();
    end
    idle();

    // Reset mid-RUN, then again mid-sweep at entry 20
    do_reset();
    repeat (20) tick();
    do_reset();
    repeat (DEPTH) begin
      probe(int'($urandom_range(0, DEPTH - 1)));
      tick();
    end

    // Every entry must hold the init value again
    for (int i = 0; i < DEPTH; i++) begin
      upd(i, 0, 1'b1);
      bp.predictAddr = AW'(i ^ mghr);
      #1;
      chk("swp_entry", bp.prediction, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
